// File: rtl/inst_encoder.sv
// inst_encoder: assembles RV32I field commands into instruction words and streams them into ROM
module inst_encoder #(
    parameter int          ADDR_W    = 12,
    parameter logic [31:0] BASE_ADDR = 32'h0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    input  logic              cmd_valid_i,
    output logic              cmd_ready_o,
    input  logic [2:0]        cmd_type_i,
    input  logic [2:0]        cmd_func3_i,
    input  logic [6:0]        cmd_func7_i,
    input  logic [4:0]        cmd_rd_i,
    input  logic [4:0]        cmd_rs1_i,
    input  logic [4:0]        cmd_rs2_i,
    input  logic [31:0]       cmd_imm_i,
    output logic              wr_en_o,
    output logic [31:0]       wr_addr_o,
    output logic [31:0]       wr_data_o,
    output logic [ADDR_W:0]   count_o,
    output logic              full_o,
    output logic              err_o,
    output logic [1:0]        err_code_o
);
    typedef enum logic [1:0] {IDLE, ENC, WR} state_t;
    typedef struct packed {
        logic [2:0]  typ;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
    } cmd_t;

    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_B     = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
    localparam logic [ADDR_W:0] FULL_CNT = {1'b1, {ADDR_W{1'b0}}};

    state_t              state_q, state_d;
    cmd_t                cmd_q, cmd_d;
    logic [31:0]         word_q, word_d;
    logic [ADDR_W:0]     count_q, count_d;
    logic                err_q, err_d;
    logic [1:0]          code_q, code_d;
    logic [31:0]         enc_word;
    logic [1:0]          enc_code;
    logic                e_fn, e_rng, e_aln;
    logic [31:0]         imm;
    logic signed [31:0]  imm_s;

    assign imm   = cmd_q.imm;
    assign imm_s = cmd_q.imm;

    // Format the latched command and flag function, range and alignment violations
    always_comb begin
        enc_word = 32'h0;
        e_fn     = 1'b0;
        e_rng    = 1'b0;
        e_aln    = 1'b0;
        case (cmd_q.typ)
            3'd0: begin
                enc_word = {imm[11:0], cmd_q.rs1, cmd_q.f3, cmd_q.rd, OP_I};
                e_rng    = imm_s < -2048 || imm_s > 2047;
            end
            3'd1: begin
                enc_word = {cmd_q.f7, imm[4:0], cmd_q.rs1, cmd_q.f3, cmd_q.rd, OP_I};
                e_fn     = !(cmd_q.f3 == 3'd1 || cmd_q.f3 == 3'd5) ||
                           !(cmd_q.f7 == 7'h00 || (cmd_q.f7 == 7'h20 && cmd_q.f3 == 3'd5));
                e_rng    = imm_s < 0 || imm_s > 31;
            end
            3'd2: begin
                enc_word = {cmd_q.f7, cmd_q.rs2, cmd_q.rs1, cmd_q.f3, cmd_q.rd, OP_R};
                e_fn     = !(cmd_q.f7 == 7'h00 ||
                             (cmd_q.f7 == 7'h20 && (cmd_q.f3 == 3'd0 || cmd_q.f3 == 3'd5)));
            end
            3'd3: begin
                enc_word = {imm[12], imm[10:5], cmd_q.rs2, cmd_q.rs1, cmd_q.f3, imm[4:1], imm[11], OP_B};
                e_fn     = cmd_q.f3 == 3'd2 || cmd_q.f3 == 3'd3;
                e_rng    = imm_s < -4096 || imm_s > 4094;
                e_aln    = imm[0];
            end
            3'd4: begin
                enc_word = {imm[20], imm[10:1], imm[11], imm[19:12], cmd_q.rd, OP_JAL};
                e_rng    = imm_s < -1048576 || imm_s > 1048574;
                e_aln    = imm[0];
            end
            3'd5: begin
                enc_word = {imm[11:0], cmd_q.rs1, 3'b000, cmd_q.rd, OP_JALR};
                e_fn     = cmd_q.f3 != 3'd0;
                e_rng    = imm_s < -2048 || imm_s > 2047;
            end
            3'd6: begin
                enc_word = {imm[31:12], cmd_q.rd, OP_LUI};
                e_aln    = imm[11:0] != 12'h0;
            end
            default: begin
                enc_word = {imm[31:12], cmd_q.rd, OP_AUIPC};
                e_aln    = imm[11:0] != 12'h0;
            end
        endcase
        enc_code = e_fn ? 2'd3 : e_rng ? 2'd1 : e_aln ? 2'd2 : 2'd0;
    end

    // Sequencer: accept, encode/check, write; start_i overrides everything
    always_comb begin
        state_d = state_q;
        cmd_d   = cmd_q;
        word_d  = word_q;
        count_d = count_q;
        err_d   = err_q;
        code_d  = code_q;
        if (start_i) begin
            state_d = IDLE;
            count_d = '0;
            err_d   = 1'b0;
        end else begin
            case (state_q)
                IDLE: if (cmd_valid_i && cmd_ready_o) begin
                    cmd_d.typ = cmd_type_i;
                    cmd_d.f3  = cmd_func3_i;
                    cmd_d.f7  = cmd_func7_i;
                    cmd_d.rd  = cmd_rd_i;
                    cmd_d.rs1 = cmd_rs1_i;
                    cmd_d.rs2 = cmd_rs2_i;
                    cmd_d.imm = cmd_imm_i;
                    state_d   = ENC;
                end
                ENC: if (enc_code != 2'd0) begin
                    err_d   = 1'b1;
                    code_d  = enc_code;
                    state_d = IDLE;
                end else begin
                    word_d  = enc_word;
                    state_d = WR;
                end
                WR: begin
                    count_d = count_q + 1'b1;
                    state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cmd_q   <= '0;
            word_q  <= '0;
            count_q <= '0;
            err_q   <= 1'b0;
            code_q  <= '0;
        end else begin
            state_q <= state_d;
            cmd_q   <= cmd_d;
            word_q  <= word_d;
            count_q <= count_d;
            err_q   <= err_d;
            code_q  <= code_d;
        end
    end

    assign full_o      = count_q == FULL_CNT;
    assign cmd_ready_o = (state_q == IDLE) && !full_o && !start_i && !rst;
    assign wr_en_o     = (state_q == WR) && !start_i && !rst;
    assign wr_addr_o   = BASE_ADDR + 32'({count_q, 2'b00});
    assign wr_data_o   = word_q;
    assign count_o     = count_q;
    assign err_o       = err_q;
    assign err_code_o  = code_q;
endmodule

// File: tb/tb_inst_encoder.sv
// tb_inst_encoder: randomized and directed check of inst_encoder against an arithmetic RV32I model
module tb_inst_encoder;
    localparam int          AW   = 2;
    localparam logic [31:0] BASE = 32'h0000_0100;

    logic        clk = 1'b0, rst = 1'b1, start_i = 1'b0, cmd_valid_i = 1'b0;
    logic        cmd_ready_o;
    logic [2:0]  cmd_type_i = '0, cmd_func3_i = '0;
    logic [6:0]  cmd_func7_i = '0;
    logic [4:0]  cmd_rd_i = '0, cmd_rs1_i = '0, cmd_rs2_i = '0;
    logic [31:0] cmd_imm_i = '0;
    logic        wr_en_o;
    logic [31:0] wr_addr_o, wr_data_o;
    logic [AW:0] count_o;
    logic        full_o, err_o;
    logic [1:0]  err_code_o;

    int n_chk = 0, n_fail = 0;
    int m_count = 0, m_code = 0;
    bit m_err = 1'b0;
    int bnd [16] = '{2047, 2048, -2048, -2049, 4094, 4095, -4096, -4098,
                     31, 32, -1, 1048574, 1048576, -1048576, 3, 'h12345001};

    inst_encoder #(.ADDR_W(AW), .BASE_ADDR(BASE)) dut (
        .clk(clk), .rst(rst), .start_i(start_i),
        .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o),
        .cmd_type_i(cmd_type_i), .cmd_func3_i(cmd_func3_i), .cmd_func7_i(cmd_func7_i),
        .cmd_rd_i(cmd_rd_i), .cmd_rs1_i(cmd_rs1_i), .cmd_rs2_i(cmd_rs2_i), .cmd_imm_i(cmd_imm_i),
        .wr_en_o(wr_en_o), .wr_addr_o(wr_addr_o), .wr_data_o(wr_data_o),
        .count_o(count_o), .full_o(full_o), .err_o(err_o), .err_code_o(err_code_o)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h required %h", tag, got, exp);
        end
    endtask

    function automatic void model(input int typ, input int f3, input int f7, input int rd,
                                  input int rs1, input int rs2, input int imm,
                                  output logic [31:0] w, output int code);
        bit fn, rg, al;
        fn = 1'b0; rg = 1'b0; al = 1'b0; w = '0;
        case (typ)
            0: begin
                rg = imm < -2048 || imm > 2047;
                w  = ((imm & 'hFFF) << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | 'h13;
            end
            1: begin
                fn = !((f3 == 1 || f3 == 5) && (f7 == 0 || (f7 == 32 && f3 == 5)));
                rg = imm < 0 || imm > 31;
                w  = (f7 << 25) | ((imm & 31) << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | 'h13;
            end
            2: begin
                fn = !(f7 == 0 || (f7 == 32 && (f3 == 0 || f3 == 5)));
                w  = (f7 << 25) | (rs2 << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | 'h33;
            end
            3: begin
                fn = f3 == 2 || f3 == 3;
                rg = imm < -4096 || imm > 4094;
                al = (imm & 1) != 0;
                w  = (((imm >> 12) & 1) << 31) | (((imm >> 5) & 63) << 25) | (rs2 << 20) |
                     (rs1 << 15) | (f3 << 12) | (((imm >> 1) & 15) << 8) |
                     (((imm >> 11) & 1) << 7) | 'h63;
            end
            4: begin
                rg = imm < -1048576 || imm > 1048574;
                al = (imm & 1) != 0;
                w  = (((imm >> 20) & 1) << 31) | (((imm >> 1) & 1023) << 21) |
                     (((imm >> 11) & 1) << 20) | (((imm >> 12) & 255) << 12) | (rd << 7) | 'h6F;
            end
            5: begin
                fn = f3 != 0;
                rg = imm < -2048 || imm > 2047;
                w  = ((imm & 'hFFF) << 20) | (rs1 << 15) | (rd << 7) | 'h67;
            end
            6: begin
                al = (imm & 'hFFF) != 0;
                w  = (imm & 32'hFFFFF000) | (rd << 7) | 'h37;
            end
            default: begin
                al = (imm & 'hFFF) != 0;
                w  = (imm & 32'hFFFFF000) | (rd << 7) | 'h17;
            end
        endcase
        code = fn ? 3 : rg ? 1 : al ? 2 : 0;
    endfunction

    task automatic drive(input int typ, input int f3, input int f7, input int rd,
                         input int rs1, input int rs2, input int imm);
        cmd_type_i  = 3'(typ);
        cmd_func3_i = 3'(f3);
        cmd_func7_i = 7'(f7);
        cmd_rd_i    = 5'(rd);
        cmd_rs1_i   = 5'(rs1);
        cmd_rs2_i   = 5'(rs2);
        cmd_imm_i   = imm;
    endtask

    task automatic run_cmd(input int typ, input int f3, input int f7, input int rd,
                           input int rs1, input int rs2, input int imm,
                           input logic [31:0] lit, input bit use_lit);
        logic [31:0] w;
        int code, waited;
        model(typ, f3, f7, rd, rs1, rs2, imm, w, code);
        if (use_lit) w = lit;
        drive(typ, f3, f7, rd, rs1, rs2, imm);
        cmd_valid_i = 1'b1;
        waited = 0;
        while (waited < 8) begin
            @(negedge clk);
            if (cmd_ready_o) break;
            waited++;
        end
        if (waited == 8) begin
            check("accept_timeout", 32'(cmd_ready_o), 1);
            cmd_valid_i = 1'b0;
            @(posedge clk); #1;
            return;
        end
        @(posedge clk); #1;
        cmd_valid_i = 1'b0;
        @(negedge clk);
        check("wr_en_enc", 32'(wr_en_o), 0);
        @(negedge clk);
        check("wr_en", 32'(wr_en_o), 32'(code == 0));
        if (code == 0) begin
            check("wr_addr", wr_addr_o, BASE + 32'(4 * m_count));
            check("wr_data", wr_data_o, w);
            m_count++;
        end else begin
            m_err  = 1'b1;
            m_code = code;
        end
        @(negedge clk);
        check("count", 32'(count_o), m_count);
        check("err", 32'(err_o), 32'(m_err));
        check("err_code", 32'(err_code_o), m_code);
        check("full", 32'(full_o), 32'(m_count == 4));
        check("ready", 32'(cmd_ready_o), 32'(m_count != 4));
        @(posedge clk); #1;
    endtask

    task automatic pulse_start();
        start_i = 1'b1;
        @(negedge clk);
        check("ready_start", 32'(cmd_ready_o), 0);
        @(posedge clk); #1;
        start_i = 1'b0;
        m_count = 0;
        m_err   = 1'b0;
        @(negedge clk);
        check("count_start", 32'(count_o), 0);
        check("full_start", 32'(full_o), 0);
        check("err_start", 32'(err_o), 0);
        @(posedge clk); #1;
    endtask

    task automatic hold_off();
        drive(0, 0, 0, 1, 0, 0, 5);
        cmd_valid_i = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("ready_full", 32'(cmd_ready_o), 0);
            check("wr_en_full", 32'(wr_en_o), 0);
        end
        @(posedge clk); #1;
        cmd_valid_i = 1'b0;
        @(negedge clk);
        check("count_full", 32'(count_o), 4);
        @(posedge clk); #1;
    endtask

    initial begin
        int typ, f3, f7, imm;
        @(negedge clk);
        check("rst_ready", 32'(cmd_ready_o), 0);
        check("rst_wr_en", 32'(wr_en_o), 0);
        check("rst_addr", wr_addr_o, BASE);
        check("rst_data", wr_data_o, 0);
        check("rst_count", 32'(count_o), 0);
        check("rst_full", 32'(full_o), 0);
        check("rst_err", 32'(err_o), 0);
        check("rst_code", 32'(err_code_o), 0);
        @(posedge clk); #1;
        rst = 1'b0;

        run_cmd(0, 0, 0, 1, 0, 0, 5, 32'h00500093, 1'b1);
        run_cmd(2, 0, 'h20, 3, 1, 2, 0, 32'h402081B3, 1'b1);
        run_cmd(6, 0, 0, 5, 0, 0, 'h12345000, 32'h123452B7, 1'b1);
        run_cmd(3, 0, 0, 0, 1, 2, -4, 32'hFE208EE3, 1'b1);
        hold_off();
        pulse_start();
        run_cmd(4, 0, 0, 1, 0, 0, 8, 32'h008000EF, 1'b1);
        run_cmd(0, 0, 0, 1, 0, 0, 2048, 0, 1'b0);
        run_cmd(3, 1, 0, 0, 1, 2, 3, 0, 1'b0);
        run_cmd(3, 2, 0, 0, 1, 2, 8, 0, 1'b0);
        run_cmd(5, 0, 0, 1, 2, 0, -2048, 0, 1'b0);
        pulse_start();

        drive(0, 0, 0, 1, 0, 0, 5);
        cmd_valid_i = 1'b1;
        @(negedge clk);
        check("ready_pre_abort", 32'(cmd_ready_o), 1);
        @(posedge clk); #1;
        cmd_valid_i = 1'b0;
        start_i = 1'b1;
        @(negedge clk);
        check("wr_en_abort_enc", 32'(wr_en_o), 0);
        @(posedge clk); #1;
        start_i = 1'b0;
        repeat (2) begin
            @(negedge clk);
            check("wr_en_after_abort", 32'(wr_en_o), 0);
        end
        check("count_abort", 32'(count_o), 0);
        @(posedge clk); #1;

        run_cmd(0, 0, 0, 2, 0, 0, 7, 0, 1'b0);
        cmd_valid_i = 1'b1;
        @(negedge clk);
        @(posedge clk); #1;
        cmd_valid_i = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        check("wr_en_rst_wr", 32'(wr_en_o), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        m_count = 0; m_err = 1'b0; m_code = 0;
        @(negedge clk);
        check("count_rst", 32'(count_o), 0);
        check("data_rst", wr_data_o, 0);
        @(posedge clk); #1;

        drive(0, 0, 0, 1, 0, 0, 5);
        cmd_valid_i = 1'b1;
        start_i = 1'b1;
        @(negedge clk);
        check("ready_start_valid", 32'(cmd_ready_o), 0);
        @(posedge clk); #1;
        cmd_valid_i = 1'b0;
        start_i = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("wr_en_start_valid", 32'(wr_en_o), 0);
        end
        check("count_start_valid", 32'(count_o), 0);
        @(posedge clk); #1;

        for (int i = 0; i < 150; i++) begin
            if (m_count == 4) begin
                if ($urandom_range(0, 3) == 0) hold_off();
                pulse_start();
            end
            typ = int'($urandom_range(0, 7));
            f3  = int'($urandom_range(0, 7));
            if (typ == 1 && $urandom_range(0, 4) != 0) f3 = $urandom_range(0, 1) != 0 ? 5 : 1;
            if (typ == 5 && $urandom_range(0, 4) != 0) f3 = 0;
            case ($urandom_range(0, 3))
                0:       f7 = 0;
                1:       f7 = 32;
                2:       f7 = 0;
                default: f7 = int'($urandom_range(0, 127));
            endcase
            if ($urandom_range(0, 3) == 0) imm = bnd[$urandom_range(0, 15)];
            else case (typ)
                1:       imm = int'($urandom_range(0, 31));
                3:       imm = (int'($urandom_range(0, 4095)) - 2048) * 2;
                4:       imm = (int'($urandom_range(0, 1048575)) - 524288) * 2;
                6, 7:    imm = int'($urandom & 32'hFFFFF000);
                default: imm = int'($urandom_range(0, 4095)) - 2048;
            endcase
            run_cmd(typ, f3, f7, int'($urandom_range(0, 31)), int'($urandom_range(0, 31)),
                    int'($urandom_range(0, 31)), imm, 0, 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
